xlr8_commutation_ctrl: RTL and testbench

Six-step commutation controller for the three half-bridge FET driver pairs (SD_n/IN_n) fed by the XLR8 data-memory bus. It sequences the bridge through the six commutation steps, applies PWM to the high-side phase, inserts a programmable dead time between steps, and advances on either a CPU step strobe or a back-EMF edge on the floating phase's feedback sensor. It sits beside the other XBs and shares their dm_sel/ramadr register-decode style.

---
 rtl/xlr8_comm_pkg.sv | 47 ++++
 rtl/xlr8_comm_pwm.sv | 31 +++
 rtl/xlr8_commutation_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_xlr8_commutation_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xlr8_comm_pkg.sv
// Shared types for the six-step commutation controller: FSM states, phase modes, CTRL bits, step table.
// Latency: n/a (types and pure functions only); backpressure: n/a.
package xlr8_comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } comm_state_e;

    typedef enum logic [1:0] {
        PH_FLOAT = 2'd0,
        PH_HIGH  = 2'd1,
        PH_LOW   = 2'd2
    } ph_mode_e;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_DIR_BIT  = 1;
    localparam int CTRL_AUTO_BIT = 2;
    localparam int CTRL_STEP_BIT = 3;

    // Row index = step; within a row, element 0 is phase 1 (rows are written phase 3..1).
    localparam logic [5:0][2:0][1:0] STEP_TBL = {
        {PH_HIGH,  PH_LOW,   PH_FLOAT},   // 5: F/L/H
        {PH_HIGH,  PH_FLOAT, PH_LOW  },   // 4: L/F/H
        {PH_FLOAT, PH_HIGH,  PH_LOW  },   // 3: L/H/F
        {PH_LOW,   PH_HIGH,  PH_FLOAT},   // 2: F/H/L
        {PH_LOW,   PH_FLOAT, PH_HIGH },   // 1: H/F/L
        {PH_FLOAT, PH_LOW,   PH_HIGH }    // 0: H/L/F
    };

    function automatic logic [2:0] step_next(input logic [2:0] step, input logic dir);
        if (dir)
            return (step == 3'd0) ? 3'd5 : step - 3'd1;
        return (step >= 3'd5) ? 3'd0 : step + 3'd1;
    endfunction

    // Returns {sd, in} for one half-bridge.
    function automatic logic [1:0] phase_drive(input logic [1:0] mode, input logic pwm_on);
        case (mode)
            PH_HIGH: return {1'b1, pwm_on};
            PH_LOW:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/xlr8_comm_pwm.sv
// PWM generator: 0..254 counter with duty shadow reloaded at wrap so duty changes never glitch a period.
// Latency: pwm_on combinational from counter; backpressure: none, advances on every clken.
module xlr8_comm_pwm (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clken,
    input  logic [7:0] duty,
    output logic       pwm_on
);

    logic [7:0] cnt;
    logic [7:0] duty_shadow;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            duty_shadow <= '0;
        end else if (clken) begin
            if (cnt == 8'd254) begin
                cnt         <= '0;
                duty_shadow <= duty;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // 255-step period makes duty 255 a true 100 %.
    assign pwm_on = (cnt < duty_shadow);

endmodule

// File: rtl/xlr8_commutation_ctrl.sv
// Six-step bridge sequencer on the XLR8 data-memory bus: register decode, feedback sync, FSM, dead/blank timers.
// Latency: SD/IN registered one clk after state; feedback edge acts 4 clk after pin; backpressure: none.
module xlr8_commutation_ctrl
    import xlr8_comm_pkg::*;
#(
    parameter logic [7:0] CTRL_ADDR    = 8'd0,
    parameter logic [7:0] DUTY_ADDR    = 8'd0,
    parameter logic [7:0] DEAD_ADDR    = 8'd0,
    parameter logic [7:0] STAT_ADDR    = 8'd0,
    parameter int         BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clken,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel,
    input  logic       feedback_1,
    input  logic       feedback_2,
    input  logic       feedback_3,
    output logic       SD_1,
    output logic       SD_2,
    output logic       SD_3,
    output logic       IN_1,
    output logic       IN_2,
    output logic       IN_3
);

    localparam int BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);

    logic ctrl_sel, duty_sel, dead_sel, stat_sel;
    logic [7:0] ctrl_q, duty_q, dead_q, stat_val;
    logic strobe_q;

    logic [2:0] fb_s1, fb_s2, fb_s3, float_mask;
    logic fb_edge_q;

    comm_state_e state_q, state_d;
    logic [2:0] step_q;
    logic [7:0] dead_cnt;
    logic [BW-1:0] blank_cnt;
    logic ld_dead, ld_blank, step_adv, auto_adv;

    logic [2:0][1:0] step_row;
    logic [2:0] drv_sd, drv_in, sd_q, in_q;
    logic pwm_on;

    assign ctrl_sel = dm_sel && (ramadr == CTRL_ADDR);
    assign duty_sel = dm_sel && (ramadr == DUTY_ADDR);
    assign dead_sel = dm_sel && (ramadr == DEAD_ADDR);
    assign stat_sel = dm_sel && (ramadr == STAT_ADDR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q   <= '0;
            duty_q   <= '0;
            dead_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clken && ramwe) begin
                if (ctrl_sel) begin
                    ctrl_q                <= dbus_in;
                    ctrl_q[CTRL_STEP_BIT] <= 1'b0;
                    strobe_q <= dbus_in[CTRL_STEP_BIT] && !dbus_in[CTRL_AUTO_BIT];
                end
                if (duty_sel) duty_q <= dbus_in;
                if (dead_sel) dead_q <= dbus_in;
            end
        end
    end

    assign stat_val = {fb_s2, state_q, step_q};

    always_comb begin
        dbus_out  = '0;
        io_out_en = ramre && (ctrl_sel || duty_sel || dead_sel || stat_sel);
        if (ramre) begin
            if (ctrl_sel)      dbus_out = ctrl_q;
            else if (duty_sel) dbus_out = duty_q;
            else if (dead_sel) dbus_out = dead_q;
            else if (stat_sel) dbus_out = stat_val;
        end
    end

    assign step_row      = STEP_TBL[step_q];
    assign float_mask[0] = (step_row[0] == PH_FLOAT);
    assign float_mask[1] = (step_row[1] == PH_FLOAT);
    assign float_mask[2] = (step_row[2] == PH_FLOAT);

    // Third flop is only the edge reference; the edge itself is registered before the FSM sees it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fb_s1     <= '0;
            fb_s2     <= '0;
            fb_s3     <= '0;
            fb_edge_q <= 1'b0;
        end else begin
            fb_s1     <= {feedback_3, feedback_2, feedback_1};
            fb_s2     <= fb_s1;
            fb_s3     <= fb_s2;
            fb_edge_q <= |((fb_s2 ^ fb_s3) & float_mask);
        end
    end

    assign auto_adv = ctrl_q[CTRL_AUTO_BIT] && (blank_cnt == '0) && fb_edge_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ld_dead  = 1'b0;
        ld_blank = 1'b0;
        step_adv = 1'b0;
        if (!ctrl_q[CTRL_EN_BIT]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    ld_dead = 1'b1;
                end
                ST_DEAD: begin
                    if (clken && dead_cnt == 8'd1) begin
                        state_d  = ST_DRIVE;
                        ld_blank = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (strobe_q || auto_adv) begin
                        state_d  = ST_DEAD;
                        ld_dead  = 1'b1;
                        step_adv = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dead_cnt  <= '0;
            blank_cnt <= '0;
            step_q    <= '0;
        end else begin
            if (ld_dead)
                dead_cnt <= (dead_q == 8'd0) ? 8'd1 : dead_q;
            else if (state_q == ST_DEAD && clken && dead_cnt != 8'd0)
                dead_cnt <= dead_cnt - 8'd1;

            if (ld_blank)
                blank_cnt <= BLANK_INIT;
            else if (state_q == ST_DRIVE && clken && blank_cnt != '0)
                blank_cnt <= blank_cnt - BW'(1);

            if (step_adv)
                step_q <= step_next(step_q, ctrl_q[CTRL_DIR_BIT]);
        end
    end

    xlr8_comm_pwm u_pwm (
        .clk    (clk),
        .rstn   (rstn),
        .clken  (clken),
        .duty   (duty_q),
        .pwm_on (pwm_on)
    );

    always_comb begin
        drv_sd = '0;
        drv_in = '0;
        if (state_q == ST_DRIVE) begin
            {drv_sd[0], drv_in[0]} = phase_drive(step_row[0], pwm_on);
            {drv_sd[1], drv_in[1]} = phase_drive(step_row[1], pwm_on);
            {drv_sd[2], drv_in[2]} = phase_drive(step_row[2], pwm_on);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sd_q <= '0;
            in_q <= '0;
        end else begin
            sd_q <= drv_sd;
            in_q <= drv_in;
        end
    end

    assign SD_1 = sd_q[0];
    assign SD_2 = sd_q[1];
    assign SD_3 = sd_q[2];
    assign IN_1 = in_q[0];
    assign IN_2 = in_q[1];
    assign IN_3 = in_q[2];

endmodule

// File: tb/tb_xlr8_commutation_ctrl.sv
// Directed bench for xlr8_commutation_ctrl: register map, dead gap, manual/auto stepping, PWM, disable and reset.
module tb_xlr8_commutation_ctrl;

    localparam logic [7:0] A_CTRL = 8'h10;
    localparam logic [7:0] A_DUTY = 8'h11;
    localparam logic [7:0] A_DEAD = 8'h12;
    localparam logic [7:0] A_STAT = 8'h13;

    logic       clk = 1'b0;
    logic       rstn, clken, ramre, ramwe, dm_sel;
    logic [7:0] dbus_in, dbus_out, ramadr;
    logic       io_out_en;
    logic       fb1, fb2, fb3;
    logic       SD_1, SD_2, SD_3, IN_1, IN_2, IN_3;
    logic [2:0] sd, inn;

    int checks   = 0;
    int failures = 0;

    // Expected {SD_1,SD_2,SD_3} / {IN_1,IN_2,IN_3} per step with duty fully on.
    logic [2:0] exp_sd [6] = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011};
    logic [2:0] exp_in [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};

    assign sd  = {SD_1, SD_2, SD_3};
    assign inn = {IN_1, IN_2, IN_3};

    always #5 clk = ~clk;

    xlr8_commutation_ctrl #(
        .CTRL_ADDR    (A_CTRL),
        .DUTY_ADDR    (A_DUTY),
        .DEAD_ADDR    (A_DEAD),
        .STAT_ADDR    (A_STAT),
        .BLANK_CYCLES (64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clken      (clken),
        .dbus_in    (dbus_in),
        .dbus_out   (dbus_out),
        .io_out_en  (io_out_en),
        .ramadr     (ramadr),
        .ramre      (ramre),
        .ramwe      (ramwe),
        .dm_sel     (dm_sel),
        .feedback_1 (fb1),
        .feedback_2 (fb2),
        .feedback_3 (fb3),
        .SD_1       (SD_1),
        .SD_2       (SD_2),
        .SD_3       (SD_3),
        .IN_1       (IN_1),
        .IN_2       (IN_2),
        .IN_3       (IN_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        dm_sel = 1'b1; ramwe = 1'b1; ramadr = a; dbus_in = d;
        @(negedge clk);
        dm_sel = 1'b0; ramwe = 1'b0; dbus_in = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        dm_sel = 1'b1; ramre = 1'b1; ramadr = a;
        #1;
        d  = dbus_out;
        oe = io_out_en;
        dm_sel = 1'b0; ramre = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        logic [7:0] s;
        logic oe;
        for (int i = 0; i < 40; i++) begin
            rd(A_STAT, s, oe);
            if (s[4:3] == st) break;
            @(negedge clk);
        end
        chk({tag, "_reach_state"}, s[4:3], st);
    endtask

    task automatic adv(input logic [7:0] c, input logic [2:0] es, input string tag);
        logic [7:0] s;
        logic oe;
        wr(A_CTRL, c);
        @(negedge clk);
        rd(A_STAT, s, oe);
        chk({tag, "_gap"}, s[4:3], 2'd1);
        wait_state(2'd2, tag);
        rd(A_STAT, s, oe);
        chk({tag, "_step"}, s[2:0], es);
        @(negedge clk);
        chk({tag, "_sd"}, sd, exp_sd[es]);
        chk({tag, "_in"}, inn, exp_in[es]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic oe;
        int cnt;
        logic prev;
        bit found;

        rstn = 1'b0; clken = 1'b1; ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
        dbus_in = 8'h00; ramadr = 8'h00; fb1 = 1'b0; fb2 = 1'b0; fb3 = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state and register map
        chk("rst_sd", sd, 3'b000);
        chk("rst_in", inn, 3'b000);
        chk("idle_oe", io_out_en, 1'b0);
        chk("idle_dbus", dbus_out, 8'h00);
        rd(A_CTRL, d, oe); chk("rst_ctrl", d, 8'h00); chk("oe_ctrl", oe, 1'b1);
        rd(A_DUTY, d, oe); chk("rst_duty", d, 8'h00); chk("oe_duty", oe, 1'b1);
        rd(A_DEAD, d, oe); chk("rst_dead", d, 8'h00); chk("oe_dead", oe, 1'b1);
        rd(A_STAT, d, oe); chk("rst_stat", d, 8'h00); chk("oe_stat", oe, 1'b1);
        rd(8'h20, d, oe);  chk("unmapped_dbus", d, 8'h00); chk("unmapped_oe", oe, 1'b0);

        wr(A_CTRL, 8'hF8);
        rd(A_CTRL, d, oe); chk("ctrl_upper_strobe_rd", d, 8'hF0);
        rd(A_STAT, d, oe); chk("strobe_in_idle", d, 8'h00);
        wr(A_STAT, 8'hFF);
        rd(A_STAT, d, oe); chk("stat_ro", d, 8'h00);
        wr(A_CTRL, 8'h00);

        // Full duty, dead 4, enable: exact dead gap then step 0
        wr(A_DUTY, 8'hFF);
        wr(A_DEAD, 8'h04);
        rd(A_DUTY, d, oe); chk("duty_rd", d, 8'hFF);
        rd(A_DEAD, d, oe); chk("dead_rd", d, 8'h04);
        repeat (260) @(negedge clk);
        wr(A_CTRL, 8'h01);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rd(A_STAT, d, oe);
            if (d[4:3] == 2'd2) break;
            if (d[4:3] == 2'd1) cnt++;
            @(negedge clk);
        end
        chk("dead_gap_len", cnt, 4);
        chk("first_drive_state", d[4:3], 2'd2);
        chk("first_drive_sd_lag", sd, 3'b000);
        @(negedge clk);
        chk("step0_sd", sd, 3'b110);
        chk("step0_in", inn, 3'b100);

        // Manual stepping both directions
        for (int k = 1; k <= 6; k++) adv(8'h09, 3'(k % 6), $sformatf("fwd%0d", k));
        for (int k = 1; k <= 6; k++) adv(8'h0B, 3'((6 - k) % 6), $sformatf("rev%0d", k));

        // PWM duty 0x40, then change mid-period
        wr(A_DUTY, 8'h40);
        repeat (260) @(negedge clk);
        found = 1'b0;
        prev = IN_1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!prev && IN_1) begin found = 1'b1; break; end
            prev = IN_1;
        end
        chk("pwm_period_start", found, 1'b1);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            cnt += int'(IN_1);
            if (i == 100) begin dm_sel = 1'b1; ramwe = 1'b1; ramadr = A_DUTY; dbus_in = 8'hC0; end
            if (i == 101) begin dm_sel = 1'b0; ramwe = 1'b0; dbus_in = 8'h00; end
            @(negedge clk);
        end
        chk("pwm_old_duty_count", cnt, 64);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            cnt += int'(IN_1);
            @(negedge clk);
        end
        chk("pwm_new_duty_count", cnt, 192);

        // Auto mode with blanking, restarting DRIVE in step 0
        wr(A_DUTY, 8'hFF);
        wr(A_CTRL, 8'h00);
        wr(A_CTRL, 8'h05);
        wait_state(2'd2, "auto_enter");
        repeat (10) @(negedge clk);
        fb3 = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_STAT, d, oe);
        chk("blanked_step", d[2:0], 3'd0);
        chk("blanked_state", d[4:3], 2'd2);
        chk("stat_fb_bits", d[7:5], 3'b100);
        repeat (50) @(negedge clk);
        fb3 = 1'b0;
        repeat (3) @(negedge clk);
        rd(A_STAT, d, oe); chk("auto_lat_before", d[4:3], 2'd2);
        @(negedge clk);
        rd(A_STAT, d, oe); chk("auto_lat_state", d[4:3], 2'd1);
        chk("auto_step1", d[2:0], 3'd1);
        wait_state(2'd2, "auto_step1_drive");
        repeat (70) @(negedge clk);
        fb1 = 1'b1;
        repeat (10) @(negedge clk);
        rd(A_STAT, d, oe);
        chk("nonfloat_ignored_step", d[2:0], 3'd1);
        chk("nonfloat_ignored_state", d[4:3], 2'd2);
        fb2 = 1'b1;
        repeat (10) @(negedge clk);
        rd(A_STAT, d, oe); chk("float2_step2", d[2:0], 3'd2);
        wait_state(2'd2, "auto_step2_drive");
        wr(A_CTRL, 8'h0D);
        repeat (10) @(negedge clk);
        rd(A_STAT, d, oe); chk("strobe_in_auto_ignored", d[2:0], 3'd2);

        // Disable during DRIVE
        wr(A_CTRL, 8'h00);
        repeat (2) @(negedge clk);
        chk("disable_sd", sd, 3'b000);
        chk("disable_in", inn, 3'b000);
        rd(A_STAT, d, oe);
        chk("disable_state", d[4:3], 2'd0);
        chk("disable_step_kept", d[2:0], 3'd2);

        // Reset mid-DEAD
        wr(A_DEAD, 8'd20);
        wr(A_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        rd(A_STAT, d, oe); chk("pre_reset_dead", d[4:3], 2'd1);
        rstn = 1'b0;
        #1;
        rd(A_STAT, d, oe); chk("reset_stat", d[4:0], 5'd0);
        rd(A_CTRL, d, oe); chk("reset_ctrl", d, 8'h00);
        chk("reset_sd", sd, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
